// File: rtl/tty_writer.sv
// Byte-stream terminal front end driving a character buffer write port and cursor; TAB support via TTY_WRITER_TAB_EN.
// Latency: accepted byte -> buffer write one cycle later; line/screen clears take CHAR_HORZ_CNT / CHAR_HORZ_CNT*CHAR_VERT_CNT cycles.
// Backpressure: in_ready is low for the whole of any clear; printable/CR/BS sustain one byte per cycle.
module tty_writer #(
    parameter int CHAR_HORZ_CNT = 16,
    parameter int CHAR_VERT_CNT = 2,
    parameter int CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
    parameter int CHAR_VERT_W   = $clog2(CHAR_VERT_CNT),
    parameter int TAB_STOP      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   char_write_en,
    output logic [CHAR_HORZ_W-1:0] char_hpos,
    output logic [CHAR_VERT_W-1:0] char_vpos,
    output logic [7:0]             char_symbol,
    output logic                   cursor_en,
    output logic [CHAR_HORZ_W-1:0] cursor_hpos,
    output logic [CHAR_VERT_W-1:0] cursor_vpos
);

`ifdef TTY_WRITER_TAB_EN
    localparam bit TAB_EN = 1'b1;
`else
    localparam bit TAB_EN = 1'b0;
`endif

    localparam logic [CHAR_HORZ_W-1:0] HMAX  = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
    localparam logic [CHAR_VERT_W-1:0] VMAX  = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
    localparam logic [CHAR_HORZ_W-1:0] H_ONE = CHAR_HORZ_W'(1);
    localparam logic [CHAR_VERT_W-1:0] V_ONE = CHAR_VERT_W'(1);
    localparam logic [7:0]             SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLR_SCREEN = 2'd0,
        CLR_LINE   = 2'd1,
        IDLE       = 2'd2
    } state_t;

    state_t                 r_state,  w_state_nxt;
    logic [CHAR_HORZ_W-1:0] r_clr_h,  w_clr_h_nxt;
    logic [CHAR_VERT_W-1:0] r_clr_v,  w_clr_v_nxt;
    logic [CHAR_HORZ_W-1:0] r_cur_h,  w_cur_h_nxt;
    logic [CHAR_VERT_W-1:0] r_cur_v,  w_cur_v_nxt;
    logic                   r_wr_en,  w_wr_en_nxt;
    logic [CHAR_HORZ_W-1:0] r_wr_h,   w_wr_h_nxt;
    logic [CHAR_VERT_W-1:0] r_wr_v,   w_wr_v_nxt;
    logic [7:0]             r_wr_sym, w_wr_sym_nxt;

    logic                   w_idle;
    logic                   w_printable;
    logic                   w_line_adv;
    logic [CHAR_VERT_W-1:0] w_next_row;
    logic [31:0]            w_tab_col;

    assign w_idle      = (r_state == IDLE);
    assign w_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    // Rows wrap to the top; the buffer has no scroll.
    assign w_next_row  = (r_cur_v == VMAX) ? '0 : r_cur_v + V_ONE;
    assign w_tab_col   = ((32'(r_cur_h) / 32'(TAB_STOP)) + 32'd1) * 32'(TAB_STOP);

    always_comb begin
        w_state_nxt  = r_state;
        w_clr_h_nxt  = r_clr_h;
        w_clr_v_nxt  = r_clr_v;
        w_cur_h_nxt  = r_cur_h;
        w_cur_v_nxt  = r_cur_v;
        w_wr_en_nxt  = 1'b0;
        w_wr_h_nxt   = r_wr_h;
        w_wr_v_nxt   = r_wr_v;
        w_wr_sym_nxt = r_wr_sym;
        w_line_adv   = 1'b0;

        case (r_state)
            CLR_SCREEN: begin
                w_wr_en_nxt  = 1'b1;
                w_wr_h_nxt   = r_clr_h;
                w_wr_v_nxt   = r_clr_v;
                w_wr_sym_nxt = SPACE;
                if (r_clr_h == HMAX) begin
                    w_clr_h_nxt = '0;
                    if (r_clr_v == VMAX) begin
                        w_clr_v_nxt = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_clr_v_nxt = r_clr_v + V_ONE;
                    end
                end else begin
                    w_clr_h_nxt = r_clr_h + H_ONE;
                end
            end

            CLR_LINE: begin
                w_wr_en_nxt  = 1'b1;
                w_wr_h_nxt   = r_clr_h;
                w_wr_v_nxt   = r_cur_v;
                w_wr_sym_nxt = SPACE;
                if (r_clr_h == HMAX) begin
                    w_clr_h_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_clr_h_nxt = r_clr_h + H_ONE;
                end
            end

            IDLE: begin
                if (in_valid) begin
                    if (w_printable) begin
                        w_wr_en_nxt  = 1'b1;
                        w_wr_h_nxt   = r_cur_h;
                        w_wr_v_nxt   = r_cur_v;
                        w_wr_sym_nxt = in_data;
                        if (r_cur_h == HMAX) begin
                            // Wrap: the char write goes out first, the row clear follows.
                            w_cur_h_nxt = '0;
                            w_cur_v_nxt = w_next_row;
                            w_clr_h_nxt = '0;
                            w_state_nxt = CLR_LINE;
                        end else begin
                            w_cur_h_nxt = r_cur_h + H_ONE;
                        end
                    end else begin
                        case (in_data)
                            8'h0A: w_line_adv = 1'b1;
                            8'h0D: w_cur_h_nxt = '0;
                            8'h08: begin
                                if (r_cur_h != '0) begin
                                    w_cur_h_nxt  = r_cur_h - H_ONE;
                                    w_wr_en_nxt  = 1'b1;
                                    w_wr_h_nxt   = r_cur_h - H_ONE;
                                    w_wr_v_nxt   = r_cur_v;
                                    w_wr_sym_nxt = SPACE;
                                end
                            end
                            8'h0C: begin
                                w_cur_h_nxt = '0;
                                w_cur_v_nxt = '0;
                                w_clr_h_nxt = '0;
                                w_clr_v_nxt = '0;
                                w_state_nxt = CLR_SCREEN;
                            end
                            8'h09: begin
                                if (TAB_EN) begin
                                    if (w_tab_col >= 32'(CHAR_HORZ_CNT)) begin
                                        w_line_adv = 1'b1;
                                    end else begin
                                        w_cur_h_nxt = CHAR_HORZ_W'(w_tab_col);
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                // Line advance has no char write, so column 0 is cleared in the accept cycle.
                if (w_line_adv) begin
                    w_cur_h_nxt  = '0;
                    w_cur_v_nxt  = w_next_row;
                    w_wr_en_nxt  = 1'b1;
                    w_wr_h_nxt   = '0;
                    w_wr_v_nxt   = w_next_row;
                    w_wr_sym_nxt = SPACE;
                    w_clr_h_nxt  = H_ONE;
                    w_state_nxt  = CLR_LINE;
                end
            end

            default: begin
                w_state_nxt = CLR_SCREEN;
                w_clr_h_nxt = '0;
                w_clr_v_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= CLR_SCREEN;
            r_clr_h  <= '0;
            r_clr_v  <= '0;
            r_cur_h  <= '0;
            r_cur_v  <= '0;
            r_wr_en  <= 1'b0;
            r_wr_h   <= '0;
            r_wr_v   <= '0;
            r_wr_sym <= SPACE;
        end else begin
            r_state  <= w_state_nxt;
            r_clr_h  <= w_clr_h_nxt;
            r_clr_v  <= w_clr_v_nxt;
            r_cur_h  <= w_cur_h_nxt;
            r_cur_v  <= w_cur_v_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_wr_h   <= w_wr_h_nxt;
            r_wr_v   <= w_wr_v_nxt;
            r_wr_sym <= w_wr_sym_nxt;
        end
    end

    assign in_ready      = w_idle;
    assign cursor_en     = w_idle;
    assign cursor_hpos   = r_cur_h;
    assign cursor_vpos   = r_cur_v;
    assign char_write_en = r_wr_en;
    assign char_hpos     = r_wr_h;
    assign char_vpos     = r_wr_v;
    assign char_symbol   = r_wr_sym;

endmodule

// File: tb/tb_tty_writer.sv
// Directed bench for tty_writer at 16x2: buffer writes are logged at negedge and checked against hand-computed tables.
module tb_tty_writer;

    localparam int H = 16;
    localparam int V = 2;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic       char_write_en;
    logic [3:0] char_hpos;
    logic [0:0] char_vpos;
    logic [7:0] char_symbol;
    logic       cursor_en;
    logic [3:0] cursor_hpos;
    logic [0:0] cursor_vpos;

    always #5 clk = ~clk;

    tty_writer #(
        .CHAR_HORZ_CNT(H),
        .CHAR_VERT_CNT(V)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .char_write_en(char_write_en),
        .char_hpos    (char_hpos),
        .char_vpos    (char_vpos),
        .char_symbol  (char_symbol),
        .cursor_en    (cursor_en),
        .cursor_hpos  (cursor_hpos),
        .cursor_vpos  (cursor_vpos)
    );

    typedef struct {
        logic [3:0] h;
        logic [0:0] v;
        logic [7:0] s;
        int         cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc     = 0;
    int  low_cnt = 0;
    int  n_chk   = 0;
    int  n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : rec
        wr_t w;
        if (char_write_en) begin
            w.h = char_hpos;
            w.v = char_vpos;
            w.s = char_symbol;
            w.cyc = cyc;
            wq.push_back(w);
        end
        if (rst && !in_ready) low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [3:0] h,
                          input logic [0:0] v, input logic [7:0] s);
        logic [31:0] obs;
        obs = 32'hFFFF_FFFF;
        if (idx < wq.size()) obs = 32'({wq[idx].h, wq[idx].v, wq[idx].s});
        chk(tag, obs, 32'({h, v, s}));
    endtask

    task automatic chk_cur(input string tag, input logic [3:0] h, input logic [0:0] v);
        chk(tag, 32'({cursor_en, cursor_hpos, cursor_vpos}), 32'({1'b1, h, v}));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 200 && !acc; k++) begin
            acc = in_ready;
            tick(1);
        end
        in_valid = 1'b0;
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_ready(input int max);
        for (int k = 0; k < max && !in_ready; k++) tick(1);
        chk("ready_wait", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n41;

        // Reset state
        tick(3);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_cur_en", 32'(cursor_en), 32'd0);
        chk("rst_wr_en", 32'(char_write_en), 32'd0);
        chk("rst_wr", 32'({char_hpos, char_vpos, char_symbol}), 32'({4'd0, 1'b0, 8'h20}));
        chk("rst_cur_pos", 32'({cursor_hpos, cursor_vpos}), 32'd0);

        // Power-up screen clear
        rst = 1'b1;
        wait_ready(100);
        tick(2);
        chk("clr_cnt", wq.size(), 32'd32);
        for (int i = 0; i < 32; i++) chk_wr("clr_scr", i, 4'(i % H), 1'(i / H), 8'h20);
        chk("clr_span", 32'(wq[31].cyc - wq[0].cyc), 32'd31);
        chk_cur("clr_cur", 4'd0, 1'd0);

        // Back-to-back printable
        wq.delete(); low_cnt = 0;
        send(8'h41);
        send(8'h42);
        tick(2);
        chk("ab_cnt", wq.size(), 32'd2);
        chk_wr("ab_a", 0, 4'd0, 1'd0, 8'h41);
        chk_wr("ab_b", 1, 4'd1, 1'd0, 8'h42);
        chk("ab_consec", 32'(wq[1].cyc - wq[0].cyc), 32'd1);
        chk_cur("ab_cur", 4'd2, 1'd0);
        chk("ab_no_stall", low_cnt, 32'd0);

        // Backspace / CR
        wq.delete();
        send(8'h43);
        chk_cur("c_cur", 4'd3, 1'd0);
        send(8'h08);
        chk_cur("bs_cur", 4'd2, 1'd0);
        send(8'h0D);
        chk_cur("cr_cur", 4'd0, 1'd0);
        send(8'h08);
        chk_cur("bs0_cur", 4'd0, 1'd0);
        tick(2);
        chk("bs_cnt", wq.size(), 32'd2);
        chk_wr("bs_c", 0, 4'd2, 1'd0, 8'h43);
        chk_wr("bs_sp", 1, 4'd2, 1'd0, 8'h20);

        // Unsupported bytes, then TAB
        wq.delete();
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        send(8'h01);
        send(8'h7F);
        tick(2);
        chk("unsup_cnt", wq.size(), 32'd5);
        chk_cur("unsup_cur", 4'd5, 1'd0);
        send(8'h09);
        tick(2);
`ifdef TTY_WRITER_TAB_EN
        chk_cur("tab_cur", 4'd8, 1'd0);
        chk("tab_nowr", wq.size(), 32'd5);
        for (int i = 0; i < 5; i++) send(8'h66 + 8'(i));
        chk_cur("tab13_cur", 4'd13, 1'd0);
        low_cnt = 0;
        send(8'h09);
        wait_ready(50);
        tick(2);
        chk_cur("tabwrap_cur", 4'd0, 1'd1);
        chk("tabwrap_cnt", wq.size(), 32'd26);
        chk_wr("tabwrap_first", 10, 4'd0, 1'd1, 8'h20);
        chk_wr("tabwrap_last", 25, 4'd15, 1'd1, 8'h20);
        chk("tabwrap_stall", low_cnt, 32'd15);
`else
        chk_cur("tab_off_cur", 4'd5, 1'd0);
        chk("tab_off_nowr", wq.size(), 32'd5);
`endif

        // Form feed
        wq.delete();
        send(8'h0C);
        chk("ff_busy", 32'(in_ready), 32'd0);
        chk("ff_cur_pos", 32'({cursor_hpos, cursor_vpos}), 32'd0);
        wait_ready(100);
        tick(2);
        chk("ff_cnt", wq.size(), 32'd32);
        chk_wr("ff_first", 0, 4'd0, 1'd0, 8'h20);
        chk_wr("ff_last", 31, 4'd15, 1'd1, 8'h20);

        // Line feed
        wq.delete(); low_cnt = 0;
        send(8'h0A);
        wait_ready(50);
        tick(2);
        chk_cur("lf_cur", 4'd0, 1'd1);
        chk("lf_cnt", wq.size(), 32'd16);
        chk_wr("lf_first", 0, 4'd0, 1'd1, 8'h20);
        chk_wr("lf_last", 15, 4'd15, 1'd1, 8'h20);
        chk("lf_stall", low_cnt, 32'd15);

        // Fill row 1 up to the last column (ends with 0x7E)
        wq.delete();
        for (int i = 0; i < 15; i++) send(8'h70 + 8'(i));
        tick(2);
        chk_cur("fill_cur", 4'd15, 1'd1);
        chk("fill_cnt", wq.size(), 32'd15);
        chk_wr("fill_tilde", 14, 4'd14, 1'd1, 8'h7E);

        // Wrap from the bottom-right corner to the top row
        wq.delete(); low_cnt = 0;
        send(8'h5A);
        wait_ready(50);
        tick(2);
        chk_cur("wrap_cur", 4'd0, 1'd0);
        chk("wrap_cnt", wq.size(), 32'd17);
        chk_wr("wrap_z", 0, 4'd15, 1'd1, 8'h5A);
        chk_wr("wrap_clr0", 1, 4'd0, 1'd0, 8'h20);
        chk_wr("wrap_clr15", 16, 4'd15, 1'd0, 8'h20);
        chk("wrap_stall", low_cnt, 32'd16);

        // Held byte during a clear, reset pulsed mid-clear
        wq.delete();
        send(8'h0C);
        in_valid = 1'b1;
        in_data  = 8'h41;
        tick(10);
        chk("mid_cnt", wq.size(), 32'd9);
        n41 = 0;
        foreach (wq[i]) if (wq[i].s == 8'h41) n41++;
        chk("mid_no41", n41, 32'd0);
        rst = 1'b0;
        #1;
        chk("pulse_wr_en", 32'(char_write_en), 32'd0);
        chk("pulse_ready", 32'({in_ready, cursor_en}), 32'd0);
        wq.delete();
        #1;
        rst = 1'b1;
        wait_ready(100);
        tick(1);
        in_valid = 1'b0;
        tick(2);
        chk("rerst_cnt", wq.size(), 32'd33);
        chk_wr("rerst_first", 0, 4'd0, 1'd0, 8'h20);
        chk_wr("rerst_last", 31, 4'd15, 1'd1, 8'h20);
        chk_wr("rerst_a", 32, 4'd0, 1'd0, 8'h41);
        n41 = 0;
        for (int i = 0; i < 32 && i < wq.size(); i++) if (wq[i].s == 8'h41) n41++;
        chk("rerst_no41", n41, 32'd0);
        chk_cur("rerst_cur", 4'd1, 1'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tty_writer.md
# tty_writer

Byte-stream terminal front end that sits directly upstream of the character buffer. Accepts ASCII bytes over a valid/ready handshake, interprets printable characters and a small set of control codes, and drives the buffer's character-write port plus its cursor position/enable inputs. Because the buffer has no read-back and no reset, this block owns all screen-clearing (on reset, form feed and line advance) by issuing space writes itself.

## Interface
- CHAR_HORZ_CNT, 16, columns per screen (any value ≥ 2, not necessarily a power of two)
- CHAR_VERT_CNT, 2, rows per screen (any value ≥ 2)
- CHAR_HORZ_W, $clog2(CHAR_HORZ_CNT), column index width
- CHAR_VERT_W, $clog2(CHAR_VERT_CNT), row index width
- TAB_STOP, 4, tab stop spacing in columns (used only with TTY_WRITER_TAB_EN)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  byte offered
- in_data  input  8  ASCII byte
- in_ready  output  1  block accepts a byte this cycle; transfer on in_valid & in_ready at posedge
- char_write_en  output  1  one-cycle write strobe to buffer
- char_hpos  output  CHAR_HORZ_W  write column
- char_vpos  output  CHAR_VERT_W  write row
- char_symbol  output  8  write data
- cursor_en  output  1  cursor visible
- cursor_hpos  output  CHAR_HORZ_W  cursor column
- cursor_vpos  output  CHAR_VERT_W  cursor row

## Operation
- States: CLR_SCREEN, CLR_LINE, IDLE. in_ready = cursor_en = (state == IDLE); both decoded from registered state.
- Reset (rst low): state CLR_SCREEN, clear counter 0, char_write_en 0, char_hpos/char_vpos 0, char_symbol 8'h20, cursor (0,0), in_ready 0, cursor_en 0.
- CLR_SCREEN: one space write per cycle, row-major (0,0)…(CHAR_HORZ_CNT-1,CHAR_VERT_CNT-1); after the last write → IDLE. Cursor held at (0,0).
- CLR_LINE: one space write per cycle to columns 0…CHAR_HORZ_CNT-1 of the current cursor row; after the last write → IDLE. Cursor held.
- IDLE, on accepted byte b, with cursor (c,r); "next row" = r+1, or 0 if r = CHAR_VERT_CNT-1 (wrap to top, no scroll):
  - 0x20–0x7E: write b at (c,r). If c < CHAR_HORZ_CNT-1: cursor (c+1,r), stay IDLE. Else cursor (0,next row) → CLR_LINE.
  - 0x0A (LF): no write; cursor (0,next row) → CLR_LINE.
  - 0x0D (CR): no write; cursor (0,r); stay IDLE.
  - 0x08 (BS): c > 0: cursor (c-1,r), write 8'h20 at (c-1,r). c = 0: no effect (no reverse line wrap).
  - 0x0C (FF): cursor (0,0) → CLR_SCREEN.
  - 0x09 (TAB): see Configuration.
  - All other bytes: consumed, no effect.
- in_valid while in_ready low: byte not consumed; upstream must hold in_valid and in_data stable until transfer.
- Column/row compares use CHAR_HORZ_CNT-1 / CHAR_VERT_CNT-1 explicitly; never rely on counter overflow.

## Timing
- All outputs registered. A byte accepted at edge N produces its write (char_write_en=1 with position/symbol) in the cycle after edge N; the cursor update happens at the same edge N.
- Printable and CR/BS sustain one byte per cycle; in_ready stays high.
- Line wrap or LF accepted at edge N: clear writes occur in the cycles after edges N+1…N+CHAR_HORZ_CNT (after N…N+CHAR_HORZ_CNT-1 for LF); in_ready returns high the cycle after the last clear write.
- FF accepted at edge N: CHAR_HORZ_CNT·CHAR_VERT_CNT clear writes, the first in the cycle after edge N+1.
- After rst deasserts: first clear write in the cycle after the first posedge; in_ready first high after CHAR_HORZ_CNT·CHAR_VERT_CNT writes.
- rst asserted mid-clear or mid-stream: immediate return to reset values; the full screen clear restarts from (0,0).

## Configuration
- TTY_WRITER_TAB_EN defined: 0x09 moves the cursor to the next multiple of TAB_STOP strictly greater than c, with no write; if that column ≥ CHAR_HORZ_CNT, it behaves exactly as LF.
- Not defined: 0x09 is consumed with no effect, the same as other unsupported bytes.

## Test plan
- Reset, default params → exactly 32 writes of 0x20 covering (0,0)…(15,1) in row-major order; in_ready high on the next cycle; cursor (0,0), cursor_en 1.
- Send "A","B" back-to-back → writes 0x41@(0,0), 0x42@(1,0) on consecutive cycles; cursor (2,0); in_ready never drops.
- Cursor (15,1), send "Z" → write 0x5A@(15,1); cursor (0,0); 16 space writes to row 0; in_ready low for 16 cycles.
- Cursor (3,0), send BS → space written @(2,0), cursor (2,0); CR → cursor (0,0) with no write; another BS → no write, cursor unchanged.
- Hold in_valid with 0x41 during a CLR_SCREEN, then pulse rst low mid-clear → no write of 0x41 during either clear; the clear restarts at (0,0); 0x41 is written @(0,0) after 32 writes.
- With TTY_WRITER_TAB_EN: cursor (5,0), TAB → cursor (8,0) with no write; cursor (13,0), TAB → cursor (0,1) followed by a row-1 clear. Without the macro, TAB leaves cursor (5,0).
